// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC sequencer for the instruction-fetch stage.
// Optional misaligned-redirect trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic [31:0] BranchTarget,
  input  logic        BranchTaken,
  input  logic [31:0] JumpTarget,
  input  logic        Jump,
  input  logic        Stall,
  input  logic        FetchReady,
  output logic [31:0] PCResult,
  output logic        FetchValid,
  output logic        Flush,
  output logic [31:0] FetchCount,
  output logic        AddrError
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] BUBBLE = 2'd2;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic [1:0]  state;
  logic        redirect;
  logic        accept;
  logic        target_bad;
  logic [31:0] target;
  logic [31:0] redirect_pc;

  always_comb begin
    redirect    = Jump | BranchTaken;
    target      = Jump ? JumpTarget : BranchTarget;
    target_bad  = ALIGN_CHECK && (target[1:0] != 2'b00);
    redirect_pc = target_bad ? EXC_VECTOR : target;
    accept      = FetchValid && FetchReady && !Stall;
  end

  // FetchValid is registered alongside state so it is high exactly in RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= BOOT;
      PCResult   <= RESET_PC;
      FetchValid <= 1'b0;
      Flush      <= 1'b0;
      FetchCount <= '0;
    end else if (redirect) begin
      state      <= BUBBLE;
      PCResult   <= redirect_pc;
      FetchValid <= 1'b0;
      Flush      <= 1'b1;
    end else begin
      Flush <= 1'b0;
      case (state)
        BOOT, BUBBLE: begin
          state      <= RUN;
          FetchValid <= 1'b1;
        end
        RUN: begin
          FetchValid <= 1'b1;
          if (accept) begin
            PCResult   <= PCAddResult;
            FetchCount <= FetchCount + 32'd1;
          end
        end
        default: begin
          state      <= BOOT;
          FetchValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      AddrError <= 1'b0;
    else if (redirect && target_bad)
      AddrError <= 1'b1;
  end
`else
  assign AddrError = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed plan sequences plus random stimulus.
// Honours PC_ALIGN_CHECK_EN the same way the design does.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_add;
  logic [31:0] br_tgt;
  logic        br;
  logic [31:0] j_tgt;
  logic        j;
  logic        stall;
  logic        ready;
  logic [31:0] pc;
  logic        valid;
  logic        flush;
  logic [31:0] count;
  logic        err;

  always #5 clk = ~clk;

  // External PC adder
  assign pc_add = pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .Clk(clk), .Reset(rst), .PCAddResult(pc_add),
    .BranchTarget(br_tgt), .BranchTaken(br),
    .JumpTarget(j_tgt), .Jump(j),
    .Stall(stall), .FetchReady(ready),
    .PCResult(pc), .FetchValid(valid), .Flush(flush),
    .FetchCount(count), .AddrError(err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic [31:0] count;
    logic        err;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: observable outputs after the next edge
  logic [31:0] m_pc    = RESET_PC;
  logic        m_valid = 1'b0;
  logic        m_flush = 1'b0;
  logic [31:0] m_count = '0;
  logic        m_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [31:0] bt,
                       input logic jj, input logic [31:0] jt,
                       input logic s, input logic rd);
    exp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; br = b; br_tgt = bt; j = jj; j_tgt = jt; stall = s; ready = rd;
    tgt = jj ? jt : bt;
    if (r) begin
      m_pc = RESET_PC; m_valid = 0; m_flush = 0; m_count = 0; m_err = 0;
    end else if (jj || b) begin
      if (ALIGN && tgt[1:0] != 2'b00) begin
        m_pc  = EXC_VECTOR;
        m_err = 1'b1;
      end else begin
        m_pc = tgt;
      end
      m_flush = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_flush = 1'b0;
      if (m_valid && rd && !s) begin
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
      m_valid = 1'b1;
    end
    e.pc = m_pc; e.valid = m_valid; e.flush = m_flush; e.count = m_count; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic run(input int unsigned n, input logic s, input logic rd);
    for (int unsigned i = 0; i < n; i++) drive(0, 0, '0, 0, '0, s, rd);
  endtask

  // Absolute checks one edge after the last drive
  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc",    pc,    e.pc);
        check("valid", {31'b0, valid}, {31'b0, e.valid});
        check("flush", {31'b0, flush}, {31'b0, e.flush});
        check("count", count, e.count);
        check("err",   {31'b0, err},   {31'b0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] t1, t2;
    int unsigned waited;
    rst = 1; br = 0; br_tgt = '0; j = 0; j_tgt = '0; stall = 0; ready = 0;

    // Reset then four free-running cycles
    drive(1, 0, '0, 0, '0, 0, 1);
    settle();
    check("reset_pc", pc, RESET_PC);
    check("reset_valid", {31'b0, valid}, 32'd0);
    run(4, 0, 1);
    settle();
    check("seq_pc", pc, 32'h0000_000C);
    check("seq_count", count, 32'd3);

    // Hold at 0x10 via !FetchReady, then via Stall
    run(1, 0, 1);
    run(3, 0, 0);
    settle();
    check("hold_ready_pc", pc, 32'h0000_0010);
    check("hold_ready_count", count, 32'd4);
    run(3, 1, 1);
    settle();
    check("hold_stall_pc", pc, 32'h0000_0010);
    check("hold_stall_count", count, 32'd4);

    // Jump beats branch at 0x20
    run(4, 0, 1);
    drive(0, 1, 32'h0000_0100, 1, 32'h0000_0400, 0, 1);
    settle();
    check("jump_pc", pc, 32'h0000_0400);
    check("jump_flush", {31'b0, flush}, 32'd1);
    check("jump_valid", {31'b0, valid}, 32'd0);
    check("jump_count", count, 32'd8);
    run(2, 0, 1);
    settle();
    check("jump_next_pc", pc, 32'h0000_0404);

    // Wrap from the top of the address space
    drive(0, 0, '0, 1, 32'hFFFF_FFFC, 0, 1);
    run(2, 0, 1);
    settle();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_err", {31'b0, err}, 32'd0);

    // Misaligned branch target
    drive(0, 1, 32'h0000_0102, 0, '0, 0, 1);
    run(3, 0, 1);
    settle();
    check("align_err", {31'b0, err}, ALIGN ? 32'd1 : 32'd0);
    t1 = ALIGN ? EXC_VECTOR + 32'd8 : 32'h0000_010A;
    check("align_pc", pc, t1);

    // Reset during BUBBLE, with a redirect also pending
    drive(0, 0, '0, 1, 32'h0000_0800, 0, 1);
    drive(1, 1, 32'h0000_0900, 0, '0, 0, 1);
    settle();
    check("bubble_rst_pc", pc, RESET_PC);
    check("bubble_rst_valid", {31'b0, valid}, 32'd0);
    check("bubble_rst_flush", {31'b0, flush}, 32'd0);
    check("bubble_rst_count", count, 32'd0);
    check("bubble_rst_err", {31'b0, err}, 32'd0);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      t1 = $urandom & 32'hFFFF_FFFC;
      t2 = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t1[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) t2[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 9) == 0, t1,
            $urandom_range(0, 11) == 0, t2,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0);
    end
    run(2, 0, 1);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and next-PC sequencer for the instruction-fetch stage. It sits directly upstream of the 32-bit PC adder: it drives the current PC into the adder's first input and registers the adder's PC+4 result, a branch target or a jump target as the next PC. It presents a valid/ready fetch request to instruction memory, absorbs pipeline stalls, and emits a one-cycle flush to the IF/ID register on every redirect.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: PC loaded on a misaligned redirect (only with PC_ALIGN_CHECK_EN).
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset, sampled on rising Clk.
- PCAddResult  in  32  PC+4 from the external adder, combinational from PCResult.
- BranchTarget  in  32  branch destination.
- BranchTaken  in  1  redirect to BranchTarget this cycle.
- JumpTarget  in  32  jump destination.
- Jump  in  1  redirect to JumpTarget this cycle.
- Stall  in  1  hold PC, from the hazard unit.
- FetchReady  in  1  instruction memory accepts the request.
- PCResult  out  32  current PC; fetch address and adder input A.
- FetchValid  out  1  PCResult is a valid fetch request.
- Flush  out  1  one-cycle pulse that squashes IF/ID.
- FetchCount  out  32  number of accepted fetches.
- AddrError  out  1  misaligned redirect seen (PC_ALIGN_CHECK_EN only; otherwise tied 0).

## Operation
- States:
  - BOOT: entered on Reset.
  - RUN
  - BUBBLE: one dead cycle after a redirect.
- Reset values: PCResult=RESET_PC, FetchValid=0, Flush=0, FetchCount=0, AddrError=0, state=BOOT.
- BOOT: FetchValid=0, PC is held. Next cycle goes to RUN, unless a redirect arrives (see below).
- RUN: FetchValid=1.
  - An accept is FetchValid && FetchReady && !Stall.
  - On accept: PCResult <= PCAddResult and FetchCount <= FetchCount+1.
  - Otherwise PCResult holds, so the request is stable until accepted.
- Redirect: Jump || BranchTaken, in any state, not gated by Stall or FetchReady.
  - Priority: Jump > BranchTaken > sequential.
  - Effect: PCResult <= selected target, Flush=1 for the next cycle only, state <= BUBBLE.
  - A redirect does not increment FetchCount, even if FetchReady is high that cycle.
- BUBBLE: FetchValid=0. Next cycle goes to RUN, unless a new redirect arrives (re-enter BUBBLE, pulse Flush again, last target wins).
- Reset during any state, including a pending redirect or BUBBLE, overrides everything. The redirect is discarded.
- Arithmetic:
  - The next PC is taken verbatim from PCAddResult. No internal add and no width extension.
  - 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
  - FetchCount wraps modulo 2^32.

## Timing
- PCResult, FetchValid, Flush, FetchCount and AddrError are all registered. Nothing combinational passes from inputs to outputs.
- First valid fetch is the 2nd rising edge after Reset deasserts (one BOOT cycle).
- Redirect latency: 1 cycle to the new PCResult with Flush=1, then 1 BUBBLE cycle with FetchValid=0. The target is fetched 2 cycles after the redirect was sampled.
- Stall and !FetchReady are equivalent for PC hold. Both may be high together.
- The adder path PCResult→PCAddResult→PC register must close in one cycle.

## Configuration
- PC_ALIGN_CHECK_EN:
  - Defined: a selected redirect target with bits [1:0] != 0 loads EXC_VECTOR instead. AddrError is set and stays sticky until Reset. Flush/BUBBLE behave as for any redirect.
  - Undefined: targets load unchecked and AddrError is constant 0.
  - Sequential PCAddResult values are never checked.

## Test plan
- Reset, then FetchReady=1 and Stall=0 for 4 cycles -> PCResult 0x0, 0x0 (BOOT), 0x4, 0x8, 0xC; FetchCount=3.
- In RUN at PC=0x10: FetchReady=0 for 3 cycles -> PCResult stays 0x10 and FetchCount is unchanged. Same result with Stall=1, FetchReady=1.
- At PC=0x20: Jump=1 (0x400) with BranchTaken=1 (0x100) in the same cycle -> PCResult=0x400 with Flush=1 for one cycle, FetchValid=0 for one cycle, then 0x404.
- PC=32'hFFFF_FFFC with adder result 0 -> PCResult=0x0 on accept, no error.
- With PC_ALIGN_CHECK_EN: BranchTaken to 0x102 -> PCResult=EXC_VECTOR and AddrError=1, held until Reset. Without the macro -> PCResult=0x102 and AddrError=0.
- Reset asserted in the BUBBLE cycle after a redirect -> next cycle PCResult=RESET_PC, FetchValid=0, Flush=0, FetchCount=0.
